// File: rtl/calc_entry_sequencer.sv
// Operand-entry controller: debounces ENTER, captures two switch operands, latches the settled adder sum.
// Optional live switch echo on number when CALC_SHOW_OPERAND_EN is defined.
module calc_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  output logic [3:0] num1,
  output logic [3:0] num2,
  input  logic [4:0] total,
  output logic [4:0] number,
  output logic [1:0] phase,
  output logic       result_valid
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A      = 2'b00,
    S_B      = 2'b01,
    S_SETTLE = 2'b10,
    S_SHOW   = 2'b11
  } state_t;

  state_t          state;
  logic            s1, s2;
  logic            btn_db, btn_db_d;
  logic [DW-1:0]   cnt;
  logic [SW-1:0]   scnt;
  logic [4:0]      number_r;
  logic            press;

  // Two-flop synchroniser, then the level must hold for DEBOUNCE_CYCLES before it is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn_enter;
      s2       <= s1;
      btn_db_d <= btn_db;
      if (s2 != btn_db) begin
        if (cnt == DB_LAST) begin
          btn_db <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_A;
      num1         <= 4'd0;
      num2         <= 4'd0;
      number_r     <= 5'd0;
      result_valid <= 1'b0;
      scnt         <= '0;
    end else begin
      case (state)
        S_A: begin
          if (press) begin
            num1  <= sw;
            state <= S_B;
          end
        end
        S_B: begin
          if (press) begin
            num2  <= sw;
            scnt  <= '0;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Ripple adder outputs are only trusted after the settle window.
          if (scnt == ST_LAST) begin
            number_r     <= total;
            result_valid <= 1'b1;
            state        <= S_SHOW;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        S_SHOW: begin
          if (press) begin
            num1         <= 4'd0;
            num2         <= 4'd0;
            number_r     <= 5'd0;
            result_valid <= 1'b0;
            state        <= S_A;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  assign phase = state;

`ifdef CALC_SHOW_OPERAND_EN
  always_comb begin
    number = number_r;
    case (state)
      S_A, S_B: number = {1'b0, sw};
      S_SETTLE: number = {1'b0, num2};
      default:  number = number_r;
    endcase
  end
`else
  assign number = number_r;
`endif

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Randomised and directed bench for calc_entry_sequencer against a window-based behavioural model.
module tb_calc_entry_sequencer;
  localparam int D = 16;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       btn_enter = 1'b0;
  logic [4:0] total = 5'd0;
  logic [3:0] num1, num2;
  logic [4:0] number;
  logic [1:0] phase;
  logic       result_valid;

  int checks = 0;
  int errors = 0;

  calc_entry_sequencer #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_enter(btn_enter),
    .num1(num1), .num2(num2), .total(total), .number(number),
    .phase(phase), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: accepted level flips once the synchronised level has differed from it for D straight edges.
  int         n = 0;
  int         last_flip = 0;
  bit         s2h [0:65535];
  bit         m1, m2, mdb, mdbd;
  int         mst = 0;
  int         k = 0;
  logic [3:0] mn1 = 0, mn2 = 0;
  logic [4:0] mnum = 0;
  bit         mrv = 0;
  bit         model_ok = 0;

  always @(posedge clk) begin
    bit press, flip;
    if (!rst_n) begin
      m1 = 0; m2 = 0; mdb = 0; mdbd = 0; last_flip = n;
      mst = 0; mn1 = 0; mn2 = 0; mnum = 0; mrv = 0; k = 0;
    end else begin
      s2h[n] = m2;
      flip = (n - D + 1 > last_flip);
      for (int m = n - D + 1; m <= n && flip; m++)
        if (m < 0 || s2h[m] == mdb) flip = 0;
      press = mdb & ~mdbd;
      case (mst)
        0: if (press) begin mn1 = sw; mst = 1; end
        1: if (press) begin mn2 = sw; mst = 2; k = 0; end
        2: begin
          k++;
          if (k == S) begin mnum = total; mrv = 1; mst = 3; end
        end
        default: if (press) begin mn1 = 0; mn2 = 0; mnum = 0; mrv = 0; mst = 0; end
      endcase
      mdbd = mdb;
      if (flip) begin mdb = ~mdb; last_flip = n; end
      m2 = m1;
      m1 = btn_enter;
    end
    n++;
    model_ok = 1;
  end

  function automatic logic [4:0] exp_number();
`ifdef CALC_SHOW_OPERAND_EN
    if (mst < 2) return {1'b0, sw};
    if (mst == 2) return {1'b0, mn2};
    return mnum;
`else
    return mnum;
`endif
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      chk("num1", num1, mn1);
      chk("num2", num2, mn2);
      chk("phase", phase, mst);
      chk("result_valid", result_valid, mrv);
      chk("number", number, exp_number());
    end
  end

  int a2b = 0;
  logic [1:0] prev_phase = 2'b00;
  always @(negedge clk) begin
    if (prev_phase == 2'b00 && phase == 2'b01) a2b++;
    prev_phase = phase;
  end

  task automatic cyc(input int c);
    repeat (c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [3:0] v);
    sw = v;
    btn_enter = 1'b1;
    cyc(D + 4);
    btn_enter = 1'b0;
    cyc(D + 4);
  endtask

  function automatic logic [4:0] echo(input logic [4:0] live, input logic [4:0] plain);
`ifdef CALC_SHOW_OPERAND_EN
    return live;
`else
    return plain;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with everything driven high
    sw = 4'hF; btn_enter = 1'b1; rst_n = 1'b0;
    repeat (3) begin
      cyc(1);
      chk("rst_num1", num1, 0);
      chk("rst_num2", num2, 0);
      chk("rst_number", number, echo(5'd15, 5'd0));
      chk("rst_valid", result_valid, 0);
      chk("rst_phase", phase, 0);
    end
    rst_n = 1'b1;
    cyc(D + 4);
    chk("held_through_reset_phase", phase, 1);
    chk("held_through_reset_num1", num1, 15);
    btn_enter = 1'b0;
    cyc(D + 4);

    // 9 + 7
    rst_n = 1'b0; cyc(2); rst_n = 1'b1;
    total = 5'd16;
    press(4'd9);
    press(4'd7);
    chk("sum_num1", num1, 9);
    chk("sum_num2", num2, 7);
    chk("sum_number", number, 16);
    chk("sum_valid", result_valid, 1);
    chk("sum_phase", phase, 3);
    press(4'd0);
    chk("clear_number", number, 0);
    chk("clear_valid", result_valid, 0);

    // 15 + 15 carries into bit 4
    total = 5'd30;
    press(4'd15);
    press(4'd15);
    chk("max_number", number, 30);
    chk("max_phase", phase, 3);
    press(4'd0);
    chk("exit_number", number, 0);
    chk("exit_valid", result_valid, 0);
    chk("exit_phase", phase, 0);

    // Short pulses are rejected; a long hold gives exactly one press
    repeat (5) begin
      btn_enter = 1'b1; cyc(D - 1);
      btn_enter = 1'b0; cyc(4);
    end
    cyc(D + 4);
    chk("short_pulse_phase", phase, 0);
    a2b = 0;
    btn_enter = 1'b1; cyc(100);
    btn_enter = 1'b0; cyc(D + 4);
    chk("long_hold_moves", a2b, 1);
    chk("long_hold_phase", phase, 1);

    // Reset mid-settle
    sw = 4'd3; btn_enter = 1'b1; total = 5'd12;
    for (int i = 0; i < 100 && phase != 2'b10; i++) cyc(1);
    chk("reached_settle", phase, 2);
    btn_enter = 1'b0; rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midsettle_phase", phase, 0);
    chk("midsettle_num2", num2, 0);
    chk("midsettle_valid", result_valid, 0);
    chk("midsettle_number", number, echo(5'd3, 5'd0));
    total = 5'd25;
    cyc(10);
    chk("midsettle_no_latch", number, echo(5'd3, 5'd0));
    chk("midsettle_valid_late", result_valid, 0);

    // Live echo in S_A
    sw = 4'd5;
    #1;
    chk("echo_sa", number, echo(5'd5, 5'd0));

    // Randomised bouncing button, switches, sum and occasional reset
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      btn_enter = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * D + 4);
      for (int c = 0; c < len; c++) begin
        sw = 4'($urandom);
        total = 5'($urandom_range(0, 30));
        rst_n = ($urandom_range(0, 499) != 0);
        cyc(1);
      end
    end
    rst_n = 1'b1;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
